// File: rtl/mtc2sl_link_tx.sv
// mtc2sl_link_tx: buffers valid MTC2SL words and serializes them into 8-word SL frames; CRC-8 trailer enabled by MTC2SL_TX_CRC_EN
module mtc2sl_link_tx #(
    parameter int MTC2SL_LEN = 193,
    parameter int WORD_W = 32,
    parameter int FRAME_WORDS = 8,
    parameter int FIFO_DEPTH = 4,
    parameter logic [7:0] K_HDR = 8'hBC,
    parameter logic [7:0] K_IDLE = 8'h3C
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [MTC2SL_LEN-1:0] mtc2sl,
    output logic [WORD_W-1:0]     tx_data,
    output logic [3:0]            tx_charisk,
    output logic                  tx_frame_start,
    output logic                  fifo_full,
    output logic [15:0]           ovf_cnt,
    output logic [7:0]            seq_num
);
    localparam int PAY_W = WORD_W * (FRAME_WORDS - 1);
    localparam int PAD_W = PAY_W - 8 - MTC2SL_LEN;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FRAME_WORDS);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(FRAME_WORDS - 1);
    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_d;
    logic [MTC2SL_LEN-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [MTC2SL_LEN-1:0] head;
    logic [PAY_W-1:0] shreg, shreg_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [7:0] seq, crc;
    logic [WORD_W-1:0] tx_data_d;
    logic [3:0] charisk_d;
    logic empty, valid, pop, push, drop, hdr;
    assign head = mem[rd_ptr];
    assign empty = count == '0;
    assign fifo_full = count == DEPTH;
    assign valid = mtc2sl[MTC2SL_LEN-1];
    // cnt is the index of the word currently on tx_data (0 = header)
    assign pop = (state == IDLE || cnt == LAST) && !empty;
    assign push = valid && (!fifo_full || pop);
    assign drop = valid && fifo_full && !pop;
`ifdef MTC2SL_TX_CRC_EN
    logic [PAY_W-9:0] crc_in;
    assign crc_in = {head, {PAD_W{1'b0}}};
    always_comb begin
        crc = 8'hFF;
        for (int i = PAY_W - 9; i >= 0; i--)
            crc = {crc[6:0], 1'b0} ^ ((crc[7] ^ crc_in[i]) ? 8'h07 : 8'h00);
    end
`else
    assign crc = 8'h00;
`endif
    always_comb begin
        state_d = state;
        cnt_d = cnt;
        shreg_d = shreg;
        tx_data_d = {24'h0, K_IDLE};
        charisk_d = 4'b0001;
        hdr = 1'b0;
        if (pop) begin
            state_d = SEND;
            cnt_d = '0;
            shreg_d = {head, {PAD_W{1'b0}}, crc};
            tx_data_d = {16'h0, seq, K_HDR};
            hdr = 1'b1;
        end else if (state == SEND && cnt != LAST) begin
            cnt_d = cnt + 1'b1;
            shreg_d = shreg << WORD_W;
            tx_data_d = shreg[PAY_W-1 -: WORD_W];
            charisk_d = 4'b0000;
        end else begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= mtc2sl;
    end
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            shreg <= '0;
            tx_data <= {24'h0, K_IDLE};
            tx_charisk <= 4'b0001;
            tx_frame_start <= 1'b0;
            ovf_cnt <= '0;
            seq_num <= '0;
            seq <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            shreg <= shreg_d;
            tx_data <= tx_data_d;
            tx_charisk <= charisk_d;
            tx_frame_start <= hdr;
            if (hdr) begin
                seq_num <= seq;
                seq <= seq + 8'd1;
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (drop && ovf_cnt != 16'hFFFF)
                ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
endmodule
